// File: rtl/t_mem_acc.sv
// -----------------------------------------------------------------------------
// t_mem_acc
// Transposed weight memory for the DBN processor. Holds a NUM_H x NUM_V array
// of signed BW_W-bit weights. One row can be overwritten or accumulated into
// (with per-lane saturation) per cycle. One registered read per cycle returns
// either a full row (h -> v datapath) or a full column (v -> h datapath). A
// sequenced clear wipes the array one row per enabled cycle.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   en           global enable; when low the array, the FSM and the held read
//                data keep their values
//   clr_start    start a full-array clear (ignored while a clear is running)
//   busy         clear in progress
//   wr_valid     write request; accepted when wr_valid & wr_ready & en
//   wr_ready     low during a clear and in a cycle where clr_start is raised
//   wr_mode      0 = overwrite row, 1 = saturating accumulate into row
//   wr_h_addr    target row
//   wr_data      NUM_V lanes, lane d at [BW_W*(d+1)-1 : BW_W*d]
//   rd_valid     read request; accepted when rd_valid & en & !busy
//   rd_mode      0 = row read (rd_addr = h), 1 = column read (rd_addr = v)
//   rd_addr      read address
//   out_valid    one-cycle strobe, the edge after an accepted read
//   out_row      row data (lane d = mem[h][d]); zero unless a row read
//   out_col      column data (lane e = mem[e][v]); zero unless a column read
//   sat_flag     sticky: some accumulate lane clamped; cleared by rst/clear
//   addr_err     one-cycle pulse: an accepted request had an out-of-range address
//
// Handshake: a write transfers on a rising edge where wr_valid, wr_ready and en
// are all high; wr_ready never depends on wr_valid. A read has no back-pressure
// signal: it is taken whenever rd_valid & en & !busy, and its result appears
// with out_valid exactly one edge later.
// -----------------------------------------------------------------------------
module t_mem_acc #(
    parameter int BW_W   = 11,
    parameter int NUM_V  = 10,
    parameter int NUM_H  = 10,
    parameter int ADDR_W = $clog2((NUM_H > NUM_V) ? NUM_H : NUM_V)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr_start,
    output logic                    busy,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    wr_mode,
    input  logic [ADDR_W-1:0]       wr_h_addr,
    input  logic [BW_W*NUM_V-1:0]   wr_data,
    input  logic                    rd_valid,
    input  logic                    rd_mode,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    out_valid,
    output logic [BW_W*NUM_V-1:0]   out_row,
    output logic [BW_W*NUM_H-1:0]   out_col,
    output logic                    sat_flag,
    output logic                    addr_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Address limits are compared one bit wider than the address so that a
    // dimension equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NUM_H_L  = (ADDR_W+1)'(NUM_H);
    localparam logic [ADDR_W:0]   NUM_V_L  = (ADDR_W+1)'(NUM_V);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_H - 1);
    localparam logic [BW_W-1:0]   W_MAX    = {1'b0, {(BW_W-1){1'b1}}};
    localparam logic [BW_W-1:0]   W_MIN    = {1'b1, {(BW_W-1){1'b0}}};

    logic [BW_W-1:0] mem [NUM_H][NUM_V];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_go;

    // ------------------------------------------------------------------
    // Clear sequencer: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        wr_ready = 1'b0;
        clr_go   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A pending clr_start wins over a write in the same cycle, so
                // the write is refused rather than silently lost.
                wr_ready = !clr_start;
                if (en && clr_start) begin
                    clr_go  = 1'b1;
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (en) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Write datapath: overwrite or saturating accumulate, per lane
    // ------------------------------------------------------------------
    logic              wr_acc;
    logic              wr_in_range;
    logic [ADDR_W-1:0] wr_row;
    logic [BW_W-1:0]   new_row  [NUM_V];
    logic [BW_W:0]     lane_sum [NUM_V];
    logic [NUM_V-1:0]  lane_sat;

    always_comb begin
        wr_acc      = wr_valid && wr_ready && en;
        wr_in_range = ({1'b0, wr_h_addr} < NUM_H_L);
        // Out-of-range rows are never written; the safe index only keeps the
        // read-modify-write path inside the array.
        wr_row      = wr_in_range ? wr_h_addr : '0;
        lane_sat    = '0;
        for (int d = 0; d < NUM_V; d++) begin
            lane_sum[d] = '0;
            new_row[d]  = '0;
        end
        for (int d = 0; d < NUM_V; d++) begin
            // One extra bit holds the exact sum of two BW_W-bit signed values;
            // the top two bits disagree exactly when the result does not fit.
            lane_sum[d] = {mem[wr_row][d][BW_W-1], mem[wr_row][d]}
                        + {wr_data[BW_W*d + BW_W-1], wr_data[BW_W*d +: BW_W]};
            if (!wr_mode) begin
                new_row[d] = wr_data[BW_W*d +: BW_W];
            end else if (lane_sum[d][BW_W] != lane_sum[d][BW_W-1]) begin
                lane_sat[d] = 1'b1;
                new_row[d]  = lane_sum[d][BW_W] ? W_MIN : W_MAX;
            end else begin
                new_row[d] = lane_sum[d][BW_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_H; h++) begin
                for (int d = 0; d < NUM_V; d++) begin
                    mem[h][d] <= '0;
                end
            end
        end else if (en) begin
            if (state_q == S_CLEAR) begin
                for (int d = 0; d < NUM_V; d++) begin
                    mem[cnt_q][d] <= '0;
                end
            end else if (wr_acc && wr_in_range) begin
                for (int d = 0; d < NUM_V; d++) begin
                    mem[wr_row][d] <= new_row[d];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read datapath: row or column gather from the pre-edge array contents,
    // which gives read-before-write when a write hits the same row.
    // ------------------------------------------------------------------
    logic                   rd_acc;
    logic                   rd_in_range;
    logic [ADDR_W-1:0]      rd_sel;
    logic [BW_W*NUM_V-1:0]  rd_row_bus;
    logic [BW_W*NUM_H-1:0]  rd_col_bus;

    always_comb begin
        rd_acc      = rd_valid && en && (state_q == S_IDLE);
        rd_in_range = rd_mode ? ({1'b0, rd_addr} < NUM_V_L)
                              : ({1'b0, rd_addr} < NUM_H_L);
        rd_sel      = rd_in_range ? rd_addr : '0;
        rd_row_bus  = '0;
        rd_col_bus  = '0;
        if (rd_in_range && !rd_mode) begin
            for (int d = 0; d < NUM_V; d++) begin
                rd_row_bus[BW_W*d +: BW_W] = mem[rd_sel][d];
            end
        end
        if (rd_in_range && rd_mode) begin
            for (int e = 0; e < NUM_H; e++) begin
                rd_col_bus[BW_W*e +: BW_W] = mem[e][rd_sel];
            end
        end
    end

    // out_valid and addr_err are strobes tied to an accepted request, so they
    // drop after one cycle even if en goes low; the data buses hold until the
    // next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            addr_err  <= 1'b0;
        end else begin
            out_valid <= rd_acc;
            addr_err  <= (wr_acc && !wr_in_range) || (rd_acc && !rd_in_range);
            if (rd_acc) begin
                out_row <= rd_row_bus;
                out_col <= rd_col_bus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (clr_go) begin
            sat_flag <= 1'b0;
        end else if (wr_acc && wr_in_range && wr_mode && (lane_sat != '0)) begin
            sat_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_t_mem_acc.sv
// -----------------------------------------------------------------------------
// tb_t_mem_acc
// Randomised and directed stimulus for t_mem_acc. A behavioural model (an int
// array plus a clear-cycle countdown) predicts every response. Reads push the
// expected row/column into queues; a monitor on the falling edge pops and
// compares whenever out_valid is seen. Handshake and flag outputs are checked
// by the driver around each cycle.
// -----------------------------------------------------------------------------
module tb_t_mem_acc;

    localparam int BW = 11;
    localparam int NV = 10;
    localparam int NH = 10;
    localparam int AW = 4;
    localparam int WMAX = 1023;
    localparam int WMIN = -1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             en, clr_start, busy;
    logic             wr_valid, wr_ready, wr_mode;
    logic [AW-1:0]    wr_h_addr;
    logic [BW*NV-1:0] wr_data;
    logic             rd_valid, rd_mode;
    logic [AW-1:0]    rd_addr;
    logic             out_valid;
    logic [BW*NV-1:0] out_row;
    logic [BW*NH-1:0] out_col;
    logic             sat_flag, addr_err;

    t_mem_acc dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_mode   (wr_mode),
        .wr_h_addr (wr_h_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_mode   (rd_mode),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .sat_flag  (sat_flag),
        .addr_err  (addr_err)
    );

    // ---------------- reference model ----------------
    int  model [NH][NV];
    bit  m_sat;
    int  clear_left;   // enabled cycles still to run in the current clear

    logic [BW*NV-1:0] exp_row_q [$];
    logic [BW*NH-1:0] exp_col_q [$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_zero();
        for (int h = 0; h < NH; h++)
            for (int d = 0; d < NV; d++)
                model[h][d] = 0;
    endtask

    function automatic logic [BW*NV-1:0] set_lane(input logic [BW*NV-1:0] base,
                                                  input int d, input int v);
        logic [BW*NV-1:0] r;
        r = base;
        r[BW*d +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [BW*NV-1:0] rand_data();
        logic [BW*NV-1:0] r;
        r = '0;
        for (int d = 0; d < NV; d++) begin
            case ($urandom_range(0, 3))
                0:       r = set_lane(r, d, int'($urandom_range(900, 1023)));
                1:       r = set_lane(r, d, -int'($urandom_range(900, 1024)));
                default: r = set_lane(r, d, int'($urandom_range(0, 2047)) - 1024);
            endcase
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; applies one cycle of inputs and returns at the
    // next posedge+1.
    task automatic step(input bit e, input bit cs, input bit wv, input bit wm,
                        input int wa, input logic [BW*NV-1:0] wd,
                        input bit rv, input bit rm, input int ra);
        bit               err;
        logic [BW*NV-1:0] er;
        logic [BW*NH-1:0] ec;
        logic signed [BW-1:0] lv;
        int               sum;
        en        = e;
        clr_start = cs;
        wr_valid  = wv;
        wr_mode   = wm;
        wr_h_addr = AW'(wa);
        wr_data   = wd;
        rd_valid  = rv;
        rd_mode   = rm;
        rd_addr   = AW'(ra);
        #1;
        chk("busy", busy, clear_left > 0);
        chk("wr_ready", wr_ready, (clear_left == 0) && !cs);
        err = 1'b0;
        if (e) begin
            if (rv && clear_left == 0) begin
                er = '0;
                ec = '0;
                if (!rm && ra < NH) begin
                    for (int d = 0; d < NV; d++) er = set_lane(er, d, model[ra][d]);
                end else if (rm && ra < NV) begin
                    for (int h = 0; h < NH; h++) ec[BW*h +: BW] = BW'(model[h][ra]);
                end else begin
                    err = 1'b1;
                end
                exp_row_q.push_back(er);
                exp_col_q.push_back(ec);
            end
            if (clear_left > 0) begin
                clear_left--;
            end else if (cs) begin
                model_zero();
                m_sat      = 1'b0;
                clear_left = NH;
            end else if (wv) begin
                if (wa >= NH) begin
                    err = 1'b1;
                end else begin
                    for (int d = 0; d < NV; d++) begin
                        lv = wd[BW*d +: BW];
                        if (!wm) begin
                            model[wa][d] = int'(lv);
                        end else begin
                            sum = model[wa][d] + int'(lv);
                            if (sum > WMAX) begin
                                sum   = WMAX;
                                m_sat = 1'b1;
                            end else if (sum < WMIN) begin
                                sum   = WMIN;
                                m_sat = 1'b1;
                            end
                            model[wa][d] = sum;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("addr_err", addr_err, err);
        chk("sat_flag", sat_flag, m_sat);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input bit m, input logic [BW*NV-1:0] d);
        step(1, 0, 1, m, a, d, 0, 0, 0);
    endtask

    task automatic rd(input int a, input bit m);
        step(1, 0, 0, 0, 0, '0, 1, m, a);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (exp_row_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                chk("out_row", out_row, exp_row_q.pop_front());
                chk("out_col", out_col, exp_col_q.pop_front());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [BW*NV-1:0] d0;
    logic [BW*NH-1:0] held_col;
    int               n;

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        wr_mode   = 1'b0;
        wr_h_addr = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_mode   = 1'b0;
        rd_addr   = '0;
        model_zero();
        m_sat      = 1'b0;
        clear_left = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_sat_flag", sat_flag, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_out_row", out_row, '0);
        chk("rst_out_col", out_col, '0);
        rst = 1'b0;

        // Fresh array reads back zero.
        rd(3, 0);
        idle();

        // Row 2 lane d = d-5, then column 7 sees 2 in lane 2 only.
        d0 = '0;
        for (int d = 0; d < NV; d++) d0 = set_lane(d0, d, d - 5);
        wr(2, 0, d0);
        rd(7, 1);
        held_col = '0;
        held_col[BW*2 +: BW] = BW'(2);
        idle();
        chk("held_out_col", out_col, held_col);

        // Positive saturation.
        wr(0, 0, set_lane('0, 0, 1000));
        wr(0, 1, set_lane('0, 0, 100));
        rd(0, 0);
        // Negative saturation (sat_flag stays sticky).
        wr(0, 0, set_lane('0, 1, -1000));
        wr(0, 1, set_lane('0, 1, -100));
        rd(0, 0);
        // Non-clamping accumulate round-trip.
        wr(1, 0, rand_data());
        wr(1, 1, set_lane(set_lane('0, 3, -7), 9, 5));
        rd(1, 0);

        // Out-of-range write and reads.
        wr(12, 0, rand_data());
        for (int h = 0; h < NH; h++) rd(h, 0);
        rd(12, 0);
        rd(11, 1);
        rd(10, 1);

        // Same-cycle read and write of row 4: old data first, new next.
        wr(4, 0, rand_data());
        step(1, 0, 1, 0, 4, rand_data(), 1, 0, 4);
        rd(4, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 11)), rand_data(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 11)));
        end
        while (clear_left > 0) idle();

        // Fill, then clear with a colliding write; stall 3 cycles mid-clear.
        for (int h = 0; h < NH; h++) wr(h, 0, rand_data());
        step(1, 1, 1, 0, 5, rand_data(), 1, 1, 3);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            step(!(n >= 3 && n < 6), n == 1, 1, 0, n % NH, rand_data(), 1, 0, 0);
            n++;
        end
        chk("clear_cycles", n, NH + 3);
        for (int h = 0; h < NH; h++) rd(h, 0);
        for (int v = 0; v < NV; v++) rd(v, 1);

        idle();
        idle();
        chk("pending_reads", exp_row_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
